// File: rtl/olink_tx_framer_if.sv
// ----------------------------------------------------------------------------
// olink_tx_framer_if
//
// Word-level handshake between a data source and the olink transmit framer.
//
// Signals
//   tx_word        [31:0]  data word, byte 0 is transmitted first
//   tx_word_k      [3:0]   per-byte K flags for tx_word
//   tx_word_valid          source offers tx_word / tx_word_k
//   tx_word_ready          framer accepts the word on an edge where
//                          valid and ready are both high
//
// Modports
//   master : the word source (drives word, k, valid; observes ready)
//   slave  : the framer      (observes word, k, valid; drives ready)
// ----------------------------------------------------------------------------
interface olink_tx_framer_if;
    logic [31:0] tx_word;
    logic [3:0]  tx_word_k;
    logic        tx_word_valid;
    logic        tx_word_ready;

    modport master (
        output tx_word,
        output tx_word_k,
        output tx_word_valid,
        input  tx_word_ready
    );

    modport slave (
        input  tx_word,
        input  tx_word_k,
        input  tx_word_valid,
        output tx_word_ready
    );
endinterface

// File: rtl/olink_tx_framer.sv
// ----------------------------------------------------------------------------
// olink_tx_framer
//
// Serialises 32-bit words into 16-bit half-words for a GT transmitter at one
// half per clk_link. Each loaded word is either a forced comma (inserted every
// COMMA_PERIOD word slots), an accepted user word, or the IDLE word. Accepted
// words carrying an illegal K pattern are replaced by a PAD word and counted.
//
// Parameters
//   COMMA_PERIOD   word slots between forced commas (2..256)
//
// Compile-time option
//   OLINK_TX_SPY_EN  when defined, a 64x32 capture buffer records the
//                    {tx_k, tx_d} stream after spy_start and can be read back
//                    through spy_raddr/spy_rdata. When undefined, spy_rdata
//                    is 0 and no buffer exists.
//
// Ports
//   clk_link        link user clock (only clock)
//   reset_n         synchronous active-low reset
//   tx_enable       low blocks user data; only IDLE and comma words are sent
//   tx_if           word handshake (slave side), see olink_tx_framer_if
//   tx_d [15:0]     registered half-word to GT txdata
//   tx_k [1:0]      registered charisk to GT
//   counter_reset   synchronous clear of err_count and word_count
//   err_count       illegal-K words seen, saturating
//   word_count      accepted data words, wrapping
//   spy_start       arms the spy capture
//   spy_raddr [5:0] spy read address
//   spy_rdata [31:0] spy read data, one cycle after spy_raddr
// ----------------------------------------------------------------------------
module olink_tx_framer #(
    parameter int COMMA_PERIOD = 64
) (
    input  logic                clk_link,
    input  logic                reset_n,
    input  logic                tx_enable,
    olink_tx_framer_if.slave    tx_if,
    output logic [15:0]         tx_d,
    output logic [1:0]          tx_k,
    input  logic                counter_reset,
    output logic [15:0]         err_count,
    output logic [31:0]         word_count,
    input  logic                spy_start,
    input  logic [5:0]          spy_raddr,
    output logic [31:0]         spy_rdata
);

    // ------------------------------------------------------------------------
    // Fixed words
    // ------------------------------------------------------------------------
    localparam logic [31:0] WORD_IDLE  = 32'hF7F7_F7F7;
    localparam logic [3:0]  K_IDLE     = 4'b1111;
    // K28.5 sits in byte 0 so it always lands in the low half-word.
    localparam logic [31:0] WORD_COMMA = 32'h0000_00BC;
    localparam logic [3:0]  K_COMMA    = 4'b0001;
    localparam logic [31:0] WORD_PAD   = 32'h1C1C_1C1C;
    localparam logic [3:0]  K_PAD      = 4'b1111;

    localparam logic [7:0]  COMMA_LAST = 8'(COMMA_PERIOD - 1);

    // ------------------------------------------------------------------------
    // Half-word phase: low half is loaded from the selected word, high half
    // is replayed from the stored copy on the next edge.
    // ------------------------------------------------------------------------
    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    phase_t phase_reg;
    phase_t phase_next;

    logic        hi_pending;
    logic        comma_due;
    logic        word_ready;
    logic        accept;

    logic [15:0] tx_d_reg;
    logic [15:0] tx_d_next;
    logic [1:0]  tx_k_reg;
    logic [1:0]  tx_k_next;
    logic [15:0] hi_d_reg;
    logic [15:0] hi_d_next;
    logic [1:0]  hi_k_reg;
    logic [1:0]  hi_k_next;
    logic [7:0]  slot_reg;
    logic [7:0]  slot_next;

    logic [15:0] err_count_reg;
    logic [15:0] err_count_next;
    logic [31:0] word_count_reg;
    logic [31:0] word_count_next;

    logic        word_legal;
    logic        word_is_comma;
    logic [31:0] sel_word;
    logic [3:0]  sel_k;
    logic        sel_is_comma;

    always_ff @(posedge clk_link) begin
        if (!reset_n) begin
            phase_reg <= PH_LO;
        end else begin
            phase_reg <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase_reg;
        case (phase_reg)
            PH_LO:   phase_next = PH_HI;
            PH_HI:   phase_next = PH_LO;
            default: phase_next = PH_LO;
        endcase
    end

    assign hi_pending = (phase_reg == PH_HI);
    assign comma_due  = (slot_reg == COMMA_LAST);

    // Ready comes from registers and static inputs only, never from valid,
    // so the source may wait on ready without a combinational loop.
    assign word_ready          = reset_n & tx_enable & ~hi_pending & ~comma_due;
    assign tx_if.tx_word_ready = word_ready;
    assign accept              = tx_if.tx_word_valid & word_ready;

    // ------------------------------------------------------------------------
    // K legality of the offered word
    // ------------------------------------------------------------------------
    always_comb begin
        word_is_comma = (tx_if.tx_word_k == 4'b0001) && (tx_if.tx_word[7:0] == 8'hBC);
        word_legal    = (tx_if.tx_word_k == 4'b0000) ||
                        (tx_if.tx_word_k == 4'b1111) ||
                        word_is_comma;
    end

    // ------------------------------------------------------------------------
    // Word selection: forced comma > accepted word (or PAD) > IDLE
    // ------------------------------------------------------------------------
    always_comb begin
        sel_word     = WORD_IDLE;
        sel_k        = K_IDLE;
        sel_is_comma = 1'b0;
        if (comma_due) begin
            sel_word     = WORD_COMMA;
            sel_k        = K_COMMA;
            sel_is_comma = 1'b1;
        end else if (accept) begin
            if (word_legal) begin
                sel_word     = tx_if.tx_word;
                sel_k        = tx_if.tx_word_k;
                // A user comma realigns the receiver just as well as a
                // forced one, so it restarts the comma interval too.
                sel_is_comma = word_is_comma;
            end else begin
                sel_word = WORD_PAD;
                sel_k    = K_PAD;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output half-word datapath and slot counter
    // ------------------------------------------------------------------------
    always_comb begin
        tx_d_next = tx_d_reg;
        tx_k_next = tx_k_reg;
        hi_d_next = hi_d_reg;
        hi_k_next = hi_k_reg;
        slot_next = slot_reg;
        if (!hi_pending) begin
            tx_d_next = sel_word[15:0];
            tx_k_next = sel_k[1:0];
            hi_d_next = sel_word[31:16];
            hi_k_next = sel_k[3:2];
            slot_next = sel_is_comma ? 8'd0 : slot_reg + 8'd1;
        end else begin
            tx_d_next = hi_d_reg;
            tx_k_next = hi_k_reg;
        end
    end

    // Reset discards any stored high half; slot counter starts at the comma
    // position so the first word after release is a comma.
    always_ff @(posedge clk_link) begin
        if (!reset_n) begin
            tx_d_reg <= WORD_IDLE[15:0];
            tx_k_reg <= K_IDLE[1:0];
            hi_d_reg <= WORD_IDLE[31:16];
            hi_k_reg <= K_IDLE[3:2];
            slot_reg <= COMMA_LAST;
        end else begin
            tx_d_reg <= tx_d_next;
            tx_k_reg <= tx_k_next;
            hi_d_reg <= hi_d_next;
            hi_k_reg <= hi_k_next;
            slot_reg <= slot_next;
        end
    end

    assign tx_d = tx_d_reg;
    assign tx_k = tx_k_reg;

    // ------------------------------------------------------------------------
    // Statistics counters; counter_reset wins over a same-cycle increment
    // ------------------------------------------------------------------------
    always_comb begin
        err_count_next  = err_count_reg;
        word_count_next = word_count_reg;
        if (counter_reset) begin
            err_count_next  = 16'd0;
            word_count_next = 32'd0;
        end else if (accept) begin
            word_count_next = word_count_reg + 32'd1;
            if (!word_legal && (err_count_reg != 16'hFFFF)) begin
                err_count_next = err_count_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_link) begin
        if (!reset_n) begin
            err_count_reg  <= 16'd0;
            word_count_reg <= 32'd0;
        end else begin
            err_count_reg  <= err_count_next;
            word_count_reg <= word_count_next;
        end
    end

    assign err_count  = err_count_reg;
    assign word_count = word_count_reg;

    // ------------------------------------------------------------------------
    // Spy capture buffer
    // ------------------------------------------------------------------------
`ifdef OLINK_TX_SPY_EN
    logic [31:0] spy_mem [0:63];
    logic [5:0]  spy_ptr_reg;
    logic [5:0]  spy_ptr_next;
    logic        spy_armed_reg;
    logic        spy_armed_next;
    logic        spy_wr;
    logic [31:0] spy_rdata_reg;

    // The pointer parks at 63; the armed flag lets entry 63 be written once
    // and then stops further writes so the capture is not overwritten.
    always_comb begin
        spy_ptr_next   = spy_ptr_reg;
        spy_armed_next = spy_armed_reg;
        if (spy_start) begin
            spy_ptr_next   = 6'd0;
            spy_armed_next = 1'b1;
        end else if (spy_armed_reg) begin
            if (spy_ptr_reg == 6'd63) begin
                spy_armed_next = 1'b0;
            end else begin
                spy_ptr_next = spy_ptr_reg + 6'd1;
            end
        end
    end

    assign spy_wr = reset_n & spy_armed_reg & ~spy_start;

    always_ff @(posedge clk_link) begin
        if (!reset_n) begin
            spy_ptr_reg   <= 6'd63;
            spy_armed_reg <= 1'b0;
        end else begin
            spy_ptr_reg   <= spy_ptr_next;
            spy_armed_reg <= spy_armed_next;
        end
    end

    // Plain write port and registered read port so the array maps to RAM.
    always_ff @(posedge clk_link) begin
        if (spy_wr) begin
            spy_mem[spy_ptr_reg] <= {14'h0, tx_k_reg, tx_d_reg};
        end
        spy_rdata_reg <= spy_mem[spy_raddr];
    end

    assign spy_rdata = spy_rdata_reg;
`else
    wire unused_spy = &{1'b0, spy_start, spy_raddr};

    assign spy_rdata = 32'd0;
`endif

endmodule
